// File: rtl/dif_stage_ctrl.sv
// Radix-2 SDF DIF stage sequencer: pairs half-frames for dif_butt and re-serialises L then R.
// Optional FFT_STAGE_CLIP_CNT_EN adds a saturating butterfly clip counter.
module dif_stage_ctrl #(
  parameter int IN_W         = 10,
  parameter int OUT_W        = IN_W + 1,
  parameter int STAGE        = 0,
  parameter int TOTAL_STAGES = 8
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_init,
  input  logic             i_vld,
  input  logic [IN_W-1:0]  i_I,
  input  logic [IN_W-1:0]  i_Q,
  output logic             bf_init,
  output logic             bf_vld,
  output logic [IN_W-1:0]  bf_LI,
  output logic [IN_W-1:0]  bf_LQ,
  output logic [IN_W-1:0]  bf_RI,
  output logic [IN_W-1:0]  bf_RQ,
  input  logic             bf_o_vld,
  input  logic [OUT_W-1:0] bf_o_LI,
  input  logic [OUT_W-1:0] bf_o_LQ,
  input  logic [OUT_W-1:0] bf_o_RI,
  input  logic [OUT_W-1:0] bf_o_RQ,
  input  logic             bf_o_clip,
`ifdef FFT_STAGE_CLIP_CNT_EN
  input  logic             i_clip_clr,
  output logic [15:0]      o_clip_cnt,
`endif
  output logic             o_vld,
  output logic [OUT_W-1:0] o_I,
  output logic [OUT_W-1:0] o_Q,
  output logic             o_sof,
  output logic             o_err
);

  localparam int STAGE_FFT_LEN = 2 ** (TOTAL_STAGES - STAGE);
  localparam int HALF = STAGE_FFT_LEN / 2;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  typedef enum logic {FILL, PAIR} in_st_t;
  typedef enum logic [1:0] {IDLE, LOUT, RDRAIN} out_st_t;

  in_st_t  in_st;
  out_st_t o_st;

  logic [CW-1:0] in_cnt;
  logic [CW-1:0] ret_cnt;
  logic [CW-1:0] dr_cnt;
  logic          in_last;
  logic          ret_last;
  logic          dr_last;
  logic          init_q;
  logic          in_acc;
  logic          ret_acc;

  logic [2*IN_W-1:0]  lbuf [HALF];
  logic [2*OUT_W-1:0] rbuf [HALF];

  assign in_last  = (in_cnt == LAST);
  assign ret_last = (ret_cnt == LAST);
  assign dr_last  = (dr_cnt == LAST);
  assign in_acc   = i_vld && !i_init;
  assign ret_acc  = bf_o_vld && !i_init && (o_st != RDRAIN);

  // bf_init covers the flush cycle and one more so dif_butt drains fully
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_q  <= 1'b1;
      bf_init <= 1'b1;
    end else begin
      init_q  <= i_init;
      bf_init <= i_init | init_q;
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc && in_st == FILL)
      lbuf[in_cnt] <= {i_I, i_Q};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_st  <= FILL;
      in_cnt <= '0;
      bf_vld <= 1'b0;
      bf_LI  <= '0;
      bf_LQ  <= '0;
      bf_RI  <= '0;
      bf_RQ  <= '0;
    end else begin
      bf_vld <= 1'b0;
      if (i_init) begin
        in_st  <= FILL;
        in_cnt <= '0;
      end else if (i_vld) begin
        in_cnt <= in_last ? '0 : in_cnt + CW'(1);
        unique case (in_st)
          FILL: begin
            if (in_last)
              in_st <= PAIR;
          end
          PAIR: begin
            bf_vld         <= 1'b1;
            {bf_LI, bf_LQ} <= lbuf[in_cnt];
            bf_RI          <= i_I;
            bf_RQ          <= i_Q;
            if (in_last)
              in_st <= FILL;
          end
          default: in_st <= FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret_acc)
      rbuf[ret_cnt] <= {bf_o_RI, bf_o_RQ};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_st    <= IDLE;
      ret_cnt <= '0;
      dr_cnt  <= '0;
      o_vld   <= 1'b0;
      o_I     <= '0;
      o_Q     <= '0;
      o_sof   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      o_sof <= 1'b0;
      if (i_init) begin
        o_st    <= IDLE;
        ret_cnt <= '0;
        dr_cnt  <= '0;
      end else begin
        unique case (o_st)
          IDLE, LOUT: begin
            if (bf_o_vld) begin
              o_vld   <= 1'b1;
              o_I     <= bf_o_LI;
              o_Q     <= bf_o_LQ;
              o_sof   <= (ret_cnt == '0);
              ret_cnt <= ret_last ? '0 : ret_cnt + CW'(1);
              o_st    <= ret_last ? RDRAIN : LOUT;
            end
          end
          RDRAIN: begin
            o_vld      <= 1'b1;
            {o_I, o_Q} <= rbuf[dr_cnt];
            dr_cnt     <= dr_last ? '0 : dr_cnt + CW'(1);
            if (dr_last)
              o_st <= IDLE;
            // a return here has nowhere to go
            if (bf_o_vld)
              o_err <= 1'b1;
          end
          default: o_st <= IDLE;
        endcase
      end
    end
  end

`ifdef FFT_STAGE_CLIP_CNT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_clip_cnt <= '0;
    else if (i_clip_clr)
      o_clip_cnt <= '0;
    else if (bf_o_clip && o_clip_cnt != 16'hFFFF)
      o_clip_cnt <= o_clip_cnt + 16'd1;
  end
`else
  logic clip_unused;
  assign clip_unused = bf_o_clip;
`endif

endmodule

// File: tb/tb_dif_stage_ctrl.sv
// Bench for dif_stage_ctrl with an 8-point stage and a latency-5 pass-through butterfly.
// Expected output stream is the accepted input stream, sign-extended, sof per frame start.
module tb_dif_stage_ctrl;

  localparam int IN_W  = 10;
  localparam int OUT_W = IN_W + 1;
  localparam int N     = 8;
  localparam int H     = N / 2;
  localparam int LAT   = 5;
  localparam int PW    = 1 + 4 * IN_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             i_init;
  logic             i_vld;
  logic [IN_W-1:0]  i_I;
  logic [IN_W-1:0]  i_Q;
  logic             bf_init;
  logic             bf_vld;
  logic [IN_W-1:0]  bf_LI;
  logic [IN_W-1:0]  bf_LQ;
  logic [IN_W-1:0]  bf_RI;
  logic [IN_W-1:0]  bf_RQ;
  logic             bf_o_vld;
  logic [OUT_W-1:0] bf_o_LI;
  logic [OUT_W-1:0] bf_o_LQ;
  logic [OUT_W-1:0] bf_o_RI;
  logic [OUT_W-1:0] bf_o_RQ;
  logic             bf_o_clip;
  logic             o_vld;
  logic [OUT_W-1:0] o_I;
  logic [OUT_W-1:0] o_Q;
  logic             o_sof;
  logic             o_err;
`ifdef FFT_STAGE_CLIP_CNT_EN
  logic             i_clip_clr;
  logic [15:0]      o_clip_cnt;
`endif

  dif_stage_ctrl #(
    .IN_W(IN_W),
    .OUT_W(OUT_W),
    .STAGE(0),
    .TOTAL_STAGES(3)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .i_init(i_init),
    .i_vld(i_vld),
    .i_I(i_I),
    .i_Q(i_Q),
    .bf_init(bf_init),
    .bf_vld(bf_vld),
    .bf_LI(bf_LI),
    .bf_LQ(bf_LQ),
    .bf_RI(bf_RI),
    .bf_RQ(bf_RQ),
    .bf_o_vld(bf_o_vld),
    .bf_o_LI(bf_o_LI),
    .bf_o_LQ(bf_o_LQ),
    .bf_o_RI(bf_o_RI),
    .bf_o_RQ(bf_o_RQ),
    .bf_o_clip(bf_o_clip),
`ifdef FFT_STAGE_CLIP_CNT_EN
    .i_clip_clr(i_clip_clr),
    .o_clip_cnt(o_clip_cnt),
`endif
    .o_vld(o_vld),
    .o_I(o_I),
    .o_Q(o_Q),
    .o_sof(o_sof),
    .o_err(o_err)
  );

  // butterfly stub: fixed delay, outputs are its inputs sign-extended
  logic [PW-1:0] pipe [LAT];
  logic [PW-1:0] ptail;
  assign ptail    = pipe[LAT-1];
  assign bf_o_vld = ptail[PW-1];
  assign bf_o_LI  = {ptail[4*IN_W-1], ptail[4*IN_W-1:3*IN_W]};
  assign bf_o_LQ  = {ptail[3*IN_W-1], ptail[3*IN_W-1:2*IN_W]};
  assign bf_o_RI  = {ptail[2*IN_W-1], ptail[2*IN_W-1:IN_W]};
  assign bf_o_RQ  = {ptail[IN_W-1], ptail[IN_W-1:0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bf_init) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {bf_vld, bf_LI, bf_LQ, bf_RI, bf_RQ};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [2*OUT_W:0]  exp_q  [$];
  logic [4*IN_W-1:0] pair_q [$];
  logic [2*IN_W-1:0] fbuf   [N];
  int fcnt = 0;

  function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] x);
    return {x[IN_W-1], x};
  endfunction

  function automatic void model_accept(input logic [IN_W-1:0] I,
                                       input logic [IN_W-1:0] Q);
    if (fcnt >= H) pair_q.push_back({fbuf[fcnt-H], I, Q});
    fbuf[fcnt] = {I, Q};
    exp_q.push_back({fcnt == 0, sext(I), sext(Q)});
    fcnt = (fcnt + 1) % N;
  endfunction

  function automatic void model_flush();
    repeat (fcnt) void'(exp_q.pop_back());
    fcnt = 0;
  endfunction

  // monitor
  int cyc = 0;
  int n_out = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [2*OUT_W:0]  e_out;
  logic [4*IN_W-1:0] e_pair;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bf_vld) begin
        if (pair_q.size() == 0) begin
          check("bf_pair_extra", {bf_LI, bf_LQ, bf_RI, bf_RQ}, 64'hDEAD);
        end else begin
          e_pair = pair_q.pop_front();
          check("bf_pair", {bf_LI, bf_LQ, bf_RI, bf_RQ}, e_pair);
        end
      end
      if (o_vld) begin
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
        if (exp_q.size() == 0) begin
          check("out_extra", {o_sof, o_I, o_Q}, 64'hDEAD);
        end else begin
          e_out = exp_q.pop_front();
          check("out", {o_sof, o_I, o_Q}, e_out);
        end
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] I, input logic [IN_W-1:0] Q);
    i_vld = 1'b1;
    i_I = I;
    i_Q = Q;
    model_accept(I, Q);
    @(posedge clk);
    #1 i_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || pair_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_timeout"}, t < 300, 1);
    idle(12);
  endtask

  task automatic frame_seq(input int base, input int gap);
    for (int k = 0; k < N; k++) begin
      send(IN_W'(base + k), '0);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_init = 1'b0;
    i_vld = 1'b0;
    i_I = '0;
    i_Q = '0;
    bf_o_clip = 1'b0;
`ifdef FFT_STAGE_CLIP_CNT_EN
    i_clip_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_o_vld", o_vld, 0);
    check("rst_o_sof", o_sof, 0);
    check("rst_o_err", o_err, 0);
    check("rst_o_iq", {o_I, o_Q}, 0);
    check("rst_bf_vld", bf_vld, 0);
    check("rst_bf_init", bf_init, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_bf_init_hi", bf_init, 1);
    @(negedge clk);
    check("rel_bf_init_lo", bf_init, 0);
    idle(2);

    // continuous frame
    n_out = 0;
    frame_seq(1, 0);
    drain("t1");
    check("t1_count", n_out, N);
    check("t1_span", last_cyc - first_cyc, N - 1);

    // i_vld every other cycle
    n_out = 0;
    frame_seq(1, 1);
    drain("t2");
    check("t2_count", n_out, N);
    check("t2_err", o_err, 0);

    // back-to-back frames, no output gap
    n_out = 0;
    frame_seq(1, 0);
    frame_seq(9, 0);
    drain("t3");
    check("t3_count", n_out, 2 * N);
    check("t3_span", last_cyc - first_cyc, 2 * N - 1);
    check("t3_err", o_err, 0);

    // flush after 6 samples; concurrent i_vld is ignored
    n_out = 0;
    for (int k = 1; k <= 6; k++) send(IN_W'(k), '0);
    i_init = 1'b1;
    i_vld = 1'b1;
    i_I = 10'h155;
    @(posedge clk);
    #1 i_init = 1'b0;
    i_vld = 1'b0;
    model_flush();
    @(negedge clk);
    check("t4_bf_init_1", bf_init, 1);
    check("t4_o_vld", o_vld, 0);
    @(negedge clk);
    check("t4_bf_init_2", bf_init, 1);
    @(negedge clk);
    check("t4_bf_init_3", bf_init, 0);
    idle(1);
    frame_seq(1, 0);
    drain("t4");
    check("t4_count", n_out, N);

    // async reset while draining R
    n_out = 0;
    frame_seq(1, 0);
    begin
      int t = 0;
      while (n_out < H + 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("t5_wait", t < 100, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_o_vld", o_vld, 0);
    check("t5_bf_init", bf_init, 1);
    exp_q.delete();
    pair_q.delete();
    fcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_bf_init_rel", bf_init, 1);
    idle(2);
    n_out = 0;
    frame_seq(1, 0);
    drain("t5");
    check("t5_count", n_out, N);

    // random data and random input gaps
    n_out = 0;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        send(IN_W'($urandom), IN_W'($urandom));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    drain("rnd");
    check("rnd_count", n_out, 6 * N);
    check("rnd_err", o_err, 0);

`ifdef FFT_STAGE_CLIP_CNT_EN
    check("clip_init", o_clip_cnt, 0);
    bf_o_clip = 1'b1;
    idle(100);
    bf_o_clip = 1'b0;
    @(negedge clk);
    check("clip_100", o_clip_cnt, 100);
    bf_o_clip = 1'b1;
    idle(69900);
    bf_o_clip = 1'b0;
    @(negedge clk);
    check("clip_sat", o_clip_cnt, 16'hFFFF);
    i_clip_clr = 1'b1;
    bf_o_clip = 1'b1;
    idle(1);
    i_clip_clr = 1'b0;
    bf_o_clip = 1'b0;
    @(negedge clk);
    check("clip_clr", o_clip_cnt, 0);
`endif

    check("final_err", o_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
